// File: rtl/l2_mon_pkg.sv
// rtl/l2_mon_pkg.sv - shared defaults and types for the L2 pipeline commit monitor
//
// Holds the default parameter values used by the interface and the top level,
// plus the stage-index type.
package l2_mon_pkg;

  localparam int DEF_NUM_STAGES = 4;    // stages tracked, S1..SN (>= 2)
  localparam int DEF_CNT_W      = 8;    // cycle counter width
  localparam int DEF_CNT_SAT    = 132;  // counter saturation value (< 2**CNT_W)
  localparam int DEF_MAX_CYCLES = 50;   // last count at which a commit still ends the instruction

  typedef int unsigned stage_idx_t;

endpackage

// File: rtl/l2_pipe_commit_monitor_if.sv
// rtl/l2_pipe_commit_monitor_if.sv - signal bundle between the verification wrapper and the commit monitor
//
// master: wrapper side, drives issue_i, s1_valid_i and stall_i, and observes the flags.
// slave : monitor side, observes the DUT-mirroring inputs and drives the flags
//         (start_o, started_o, stage_o, commit_o, iend_o, ended_o, ended2_o,
//          cycle_cnt_o, proto_err_o, timeout_o).
interface l2_pipe_commit_monitor_if
  import l2_mon_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int CNT_W      = DEF_CNT_W
);

  logic                  issue_i;
  logic                  s1_valid_i;
  logic [NUM_STAGES-1:0] stall_i;

  logic                  start_o;
  logic                  started_o;
  logic [NUM_STAGES-1:0] stage_o;
  logic                  commit_o;
  logic                  iend_o;
  logic                  ended_o;
  logic                  ended2_o;
  logic [CNT_W-1:0]      cycle_cnt_o;
  logic                  proto_err_o;
  logic                  timeout_o;

  modport master (
    output issue_i, s1_valid_i, stall_i,
    input  start_o, started_o, stage_o, commit_o, iend_o, ended_o, ended2_o,
           cycle_cnt_o, proto_err_o, timeout_o
  );

  modport slave (
    input  issue_i, s1_valid_i, stall_i,
    output start_o, started_o, stage_o, commit_o, iend_o, ended_o, ended2_o,
           cycle_cnt_o, proto_err_o, timeout_o
  );

endinterface

// File: rtl/l2_mon_stage.sv
// rtl/l2_mon_stage.sv - one stall-gated marker register of the tracked pipeline
//
// Ports: clk, rst_n (async active-low), adv_in (marker leaving the previous
// stage), stall (this stage's DUT stall), mark (marker is in this stage),
// adv (marker leaves this stage this cycle).
module l2_mon_stage (
  input  logic clk,
  input  logic rst_n,
  input  logic adv_in,
  input  logic stall,
  output logic mark,
  output logic adv
);

  // A stalled stage keeps its contents; otherwise it takes whatever the
  // upstream stage hands over (possibly nothing).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mark <= 1'b0;
    end else if (!stall) begin
      mark <= adv_in;
    end
  end

  assign adv = mark & ~stall;

endmodule

// File: rtl/l2_pipe_commit_monitor.sv
// rtl/l2_pipe_commit_monitor.sv - tracks one instruction marker through an N-stage stalled pipeline and flags its commit
//
// Ports: clk, rst_n (async active-low), mon (slave modport of
// l2_pipe_commit_monitor_if carrying issue/valid/stall inputs and all flags).
// Optional feature macro: L2_MON_TIMEOUT_EN enables the sticky window-overrun
// flag timeout_o; without it timeout_o is constant 0.
module l2_pipe_commit_monitor
  import l2_mon_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int CNT_SAT    = DEF_CNT_SAT,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES
) (
  input logic                      clk,
  input logic                      rst_n,
  l2_pipe_commit_monitor_if.slave  mon
);

  localparam stage_idx_t       LAST  = stage_idx_t'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0] SAT_V = CNT_W'(CNT_SAT);
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CYCLES);

  logic                  start_q;
  logic                  started_q;
  logic                  commit_q;
  logic                  ended_q;
  logic                  ended2_q;
  logic                  proto_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [NUM_STAGES-1:0] stage;
  logic [NUM_STAGES-1:0] adv;
  logic                  active;
  logic                  proto_hit;
  logic                  iend;

  assign active = start_q | started_q;

  // S1 is not a register: the marker is in S1 only during the start pulse,
  // and only if the DUT actually accepts something into S1 that cycle.
  assign stage[0] = start_q & mon.s1_valid_i & ~mon.stall_i[0];
  assign adv[0]   = stage[0];

  for (genvar k = 1; k < NUM_STAGES; k++) begin : g_stage
    l2_mon_stage u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .adv_in (adv[k-1]),
      .stall  (mon.stall_i[k]),
      .mark   (stage[k]),
      .adv    (adv[k])
    );
  end

  // Upstream hands the marker over while the receiving stage is stalled:
  // the receiving register holds, so the marker is silently dropped.
  assign proto_hit = |(adv[NUM_STAGES-2:0] & mon.stall_i[NUM_STAGES-1:1]);

  assign iend = commit_q & started_q & ~ended_q & (cnt_q <= MAX_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q   <= 1'b0;
      started_q <= 1'b0;
      commit_q  <= 1'b0;
      ended_q   <= 1'b0;
      ended2_q  <= 1'b0;
      proto_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      start_q   <= active ? 1'b0 : mon.issue_i;
      started_q <= started_q | start_q;
      commit_q  <= adv[LAST];
      ended_q   <= ended_q | iend;
      ended2_q  <= ended2_q | (commit_q & started_q & ended_q);
      proto_q   <= proto_q | proto_hit;
      if (active && (cnt_q < SAT_V)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef L2_MON_TIMEOUT_EN
  logic timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_q | (started_q & ~ended_q & (cnt_q > MAX_V));
    end
  end

  assign mon.timeout_o = timeout_q;
`else
  assign mon.timeout_o = 1'b0;
`endif

  assign mon.start_o     = start_q;
  assign mon.started_o   = started_q;
  assign mon.stage_o     = stage;
  assign mon.commit_o    = commit_q;
  assign mon.iend_o      = iend;
  assign mon.ended_o     = ended_q;
  assign mon.ended2_o    = ended2_q;
  assign mon.cycle_cnt_o = cnt_q;
  assign mon.proto_err_o = proto_q;

endmodule

// File: tb/tb_l2_pipe_commit_monitor.sv
// tb/tb_l2_pipe_commit_monitor.sv - directed self-checking bench for l2_pipe_commit_monitor
module tb_l2_pipe_commit_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       issue = 1'b0;
  logic       s1_valid = 1'b1;
  logic [3:0] stall = 4'b0;

  int vec = 0;
  int errs = 0;

`ifdef L2_MON_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  l2_pipe_commit_monitor_if #(.NUM_STAGES(4), .CNT_W(8)) bus  ();
  l2_pipe_commit_monitor_if #(.NUM_STAGES(4), .CNT_W(8)) bus2 ();

  assign bus.issue_i     = issue;
  assign bus.s1_valid_i  = s1_valid;
  assign bus.stall_i     = stall;
  assign bus2.issue_i    = issue;
  assign bus2.s1_valid_i = s1_valid;
  assign bus2.stall_i    = stall;

  l2_pipe_commit_monitor #(.NUM_STAGES(4), .CNT_W(8), .CNT_SAT(132), .MAX_CYCLES(50)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (bus.slave)
  );

  l2_pipe_commit_monitor #(.NUM_STAGES(4), .CNT_W(8), .CNT_SAT(132), .MAX_CYCLES(3)) u_late (
    .clk   (clk),
    .rst_n (rst_n),
    .mon   (bus2.slave)
  );

  task automatic do_reset();
    rst_n = 1'b0; issue = 1'b0; s1_valid = 1'b1; stall = 4'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; issue = 1'b1;
    #12;
    vec++; if (bus.start_o !== 1'b0) begin errs++; $display("FAIL reset_start got %0h expected 0", bus.start_o); end
    vec++; if (bus.started_o !== 1'b0) begin errs++; $display("FAIL reset_started got %0h expected 0", bus.started_o); end
    vec++; if (bus.stage_o !== 4'b0) begin errs++; $display("FAIL reset_stage got %0h expected 0", bus.stage_o); end
    vec++; if (bus.commit_o !== 1'b0) begin errs++; $display("FAIL reset_commit got %0h expected 0", bus.commit_o); end
    vec++; if (bus.iend_o !== 1'b0) begin errs++; $display("FAIL reset_iend got %0h expected 0", bus.iend_o); end
    vec++; if (bus.ended_o !== 1'b0) begin errs++; $display("FAIL reset_ended got %0h expected 0", bus.ended_o); end
    vec++; if (bus.ended2_o !== 1'b0) begin errs++; $display("FAIL reset_ended2 got %0h expected 0", bus.ended2_o); end
    vec++; if (bus.cycle_cnt_o !== 8'd0) begin errs++; $display("FAIL reset_cnt got %0d expected 0", bus.cycle_cnt_o); end
    vec++; if (bus.proto_err_o !== 1'b0) begin errs++; $display("FAIL reset_proto got %0h expected 0", bus.proto_err_o); end
    vec++; if (bus.timeout_o !== 1'b0) begin errs++; $display("FAIL reset_timeout got %0h expected 0", bus.timeout_o); end
    issue = 1'b0;
  endtask

  task automatic test_nominal();
    logic [3:0] es;
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      issue = (c == 0);
      #1;
      es = 4'b0;
      if (c >= 1 && c <= 4) es[c-1] = 1'b1;
      vec++; if (bus.start_o !== (c == 1)) begin errs++; $display("FAIL nom_start cycle %0d got %0h expected %0h", c, bus.start_o, (c == 1)); end
      vec++; if (bus.stage_o !== es) begin errs++; $display("FAIL nom_stage cycle %0d got %0h expected %0h", c, bus.stage_o, es); end
      vec++; if (bus.commit_o !== (c == 5)) begin errs++; $display("FAIL nom_commit cycle %0d got %0h expected %0h", c, bus.commit_o, (c == 5)); end
      vec++; if (bus.iend_o !== (c == 5)) begin errs++; $display("FAIL nom_iend cycle %0d got %0h expected %0h", c, bus.iend_o, (c == 5)); end
      vec++; if (bus.ended_o !== (c >= 6)) begin errs++; $display("FAIL nom_ended cycle %0d got %0h expected %0h", c, bus.ended_o, (c >= 6)); end
      vec++; if (bus.started_o !== (c >= 2)) begin errs++; $display("FAIL nom_started cycle %0d got %0h expected %0h", c, bus.started_o, (c >= 2)); end
      vec++; if (int'(bus.cycle_cnt_o) != ((c == 0) ? 0 : c - 1)) begin errs++; $display("FAIL nom_cnt cycle %0d got %0d expected %0d", c, bus.cycle_cnt_o, (c == 0) ? 0 : c - 1); end
      vec++; if (bus.ended2_o !== 1'b0) begin errs++; $display("FAIL nom_ended2 cycle %0d got %0h expected 0", c, bus.ended2_o); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_late_commit();
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      issue = (c == 0);
      #1;
      vec++; if (bus2.commit_o !== (c == 5)) begin errs++; $display("FAIL late_commit cycle %0d got %0h expected %0h", c, bus2.commit_o, (c == 5)); end
      vec++; if (bus2.iend_o !== 1'b0) begin errs++; $display("FAIL late_iend cycle %0d got %0h expected 0", c, bus2.iend_o); end
      vec++; if (bus2.ended_o !== 1'b0) begin errs++; $display("FAIL late_ended cycle %0d got %0h expected 0", c, bus2.ended_o); end
      vec++; if (bus2.timeout_o !== (TO_EN && c >= 6)) begin errs++; $display("FAIL late_timeout cycle %0d got %0h expected %0h", c, bus2.timeout_o, (TO_EN && c >= 6)); end
      if (c == 5) begin
        vec++; if (bus2.cycle_cnt_o !== 8'd4) begin errs++; $display("FAIL late_cnt got %0d expected 4", bus2.cycle_cnt_o); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    logic [3:0] es;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      issue = (c == 0);
      stall = (c >= 3 && c <= 5) ? 4'b0100 : 4'b0000;
      #1;
      es = 4'b0;
      if (c == 1) es = 4'b0001;
      else if (c == 2) es = 4'b0010;
      else if (c >= 3 && c <= 6) es = 4'b0100;
      else if (c == 7) es = 4'b1000;
      vec++; if (bus.stage_o !== es) begin errs++; $display("FAIL stall_stage cycle %0d got %0h expected %0h", c, bus.stage_o, es); end
      vec++; if (bus.commit_o !== (c == 8)) begin errs++; $display("FAIL stall_commit cycle %0d got %0h expected %0h", c, bus.commit_o, (c == 8)); end
      vec++; if (bus.proto_err_o !== 1'b0) begin errs++; $display("FAIL stall_proto cycle %0d got %0h expected 0", c, bus.proto_err_o); end
      if (c == 8) begin
        vec++; if (bus.cycle_cnt_o !== 8'd7) begin errs++; $display("FAIL stall_cnt got %0d expected 7", bus.cycle_cnt_o); end
        vec++; if (bus.iend_o !== 1'b1) begin errs++; $display("FAIL stall_iend got %0h expected 1", bus.iend_o); end
      end
      @(posedge clk); #1;
    end
    stall = 4'b0;
  endtask

  task automatic test_no_entry();
    do_reset();
    s1_valid = 1'b0;
    for (int c = 0; c <= 140; c++) begin
      issue = (c == 0);
      #1;
      vec++; if (bus.stage_o !== 4'b0) begin errs++; $display("FAIL noent_stage cycle %0d got %0h expected 0", c, bus.stage_o); end
      vec++; if (bus.commit_o !== 1'b0) begin errs++; $display("FAIL noent_commit cycle %0d got %0h expected 0", c, bus.commit_o); end
      @(posedge clk); #1;
    end
    #1;
    vec++; if (bus.cycle_cnt_o !== 8'd132) begin errs++; $display("FAIL noent_cnt_sat got %0d expected 132", bus.cycle_cnt_o); end
    vec++; if (bus.ended_o !== 1'b0) begin errs++; $display("FAIL noent_ended got %0h expected 0", bus.ended_o); end
    vec++; if (bus.started_o !== 1'b1) begin errs++; $display("FAIL noent_started got %0h expected 1", bus.started_o); end
    vec++; if (bus.timeout_o !== TO_EN) begin errs++; $display("FAIL noent_timeout got %0h expected %0h", bus.timeout_o, TO_EN); end
    s1_valid = 1'b1;
  endtask

  task automatic test_proto();
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      issue = (c == 0);
      stall = (c == 1) ? 4'b0010 : 4'b0000;
      #1;
      vec++; if (bus.proto_err_o !== (c >= 2)) begin errs++; $display("FAIL proto_err cycle %0d got %0h expected %0h", c, bus.proto_err_o, (c >= 2)); end
      vec++; if (bus.stage_o !== ((c == 1) ? 4'b0001 : 4'b0000)) begin errs++; $display("FAIL proto_stage cycle %0d got %0h expected %0h", c, bus.stage_o, (c == 1) ? 4'b0001 : 4'b0000); end
      vec++; if (bus.commit_o !== 1'b0) begin errs++; $display("FAIL proto_commit cycle %0d got %0h expected 0", c, bus.commit_o); end
      @(posedge clk); #1;
    end
    stall = 4'b0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    issue = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      if (c == 3) rst_n = 1'b0;
      #1;
      if (c == 1) begin
        vec++; if (bus.start_o !== 1'b1) begin errs++; $display("FAIL mid_start1 got %0h expected 1", bus.start_o); end
      end
      if (c == 2) begin
        vec++; if (bus.stage_o !== 4'b0010) begin errs++; $display("FAIL mid_stage2 got %0h expected 2", bus.stage_o); end
      end
      if (c == 3 || c == 4) begin
        vec++; if (bus.stage_o !== 4'b0) begin errs++; $display("FAIL mid_rst_stage cycle %0d got %0h expected 0", c, bus.stage_o); end
        vec++; if (bus.started_o !== 1'b0) begin errs++; $display("FAIL mid_rst_started cycle %0d got %0h expected 0", c, bus.started_o); end
        vec++; if (bus.cycle_cnt_o !== 8'd0) begin errs++; $display("FAIL mid_rst_cnt cycle %0d got %0d expected 0", c, bus.cycle_cnt_o); end
        vec++; if (bus.start_o !== 1'b0) begin errs++; $display("FAIL mid_rst_start cycle %0d got %0h expected 0", c, bus.start_o); end
      end
      if (c == 5) rst_n = 1'b1;
      if (c >= 5 && c <= 7) begin
        vec++; if (bus.start_o !== (c == 6)) begin errs++; $display("FAIL mid_restart cycle %0d got %0h expected %0h", c, bus.start_o, (c == 6)); end
      end
      if (c >= 8) begin
        vec++; if (bus.commit_o !== (c == 10)) begin errs++; $display("FAIL mid_commit cycle %0d got %0h expected %0h", c, bus.commit_o, (c == 10)); end
      end
      if (c == 10) begin
        vec++; if (bus.cycle_cnt_o !== 8'd4) begin errs++; $display("FAIL mid_cnt got %0d expected 4", bus.cycle_cnt_o); end
      end
      @(posedge clk); #1;
    end
    issue = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_late_commit();
    test_stall();
    test_no_entry();
    test_proto();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/l2_pipe_commit_monitor.md
# l2_pipe_commit_monitor

Parametrised pipeline-tracking monitor for L2 refinement checking. It sits beside the L2 DUT in a verification wrapper. It launches a single instruction marker on issue and carries it through an N-stage stall-controlled pipeline, mirroring the DUT's per-stage stall signals. It raises commit and end flags, bounded by a cycle window, for the property checker to sample. Unlike the fixed 4-stage monitors, stage count, counter width, and commit window are parameters, and an S1 valid qualifier is built in. Stall-protocol violations are also detected.

## Interface
- NUM_STAGES, 4: pipeline stages tracked (S1..SN), ≥2
- CNT_W, 8: cycle counter width
- CNT_SAT, 132: counter saturation value, < 2^CNT_W
- MAX_CYCLES, 50: last counter value at which a commit still counts as the instruction end
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_i  in  1  request to start tracking
- s1_valid_i  in  1  DUT S1 valid; marker enters only when high
- stall_i  in  NUM_STAGES  per-stage DUT stall, bit k = stage k+1
- start_o  out  1  one-cycle start pulse
- started_o  out  1  sticky, set the cycle after start_o
- stage_o  out  NUM_STAGES  marker position; bit 0 combinational, bits ≥1 registered
- commit_o  out  1  marker left SN last cycle
- iend_o  out  1  first in-window commit, combinational
- ended_o  out  1  sticky, set after iend_o
- ended2_o  out  1  sticky, second commit after ended_o
- cycle_cnt_o  out  CNT_W  cycles since start_o, saturating
- proto_err_o  out  1  sticky stall-protocol violation
- timeout_o  out  1  sticky window overrun (see Configuration)

## Operation
- Reset (rst_n=0, async) clears all registered outputs to 0: start_o, started_o, stage_o[N-1:1], commit_o, ended_o, ended2_o, cycle_cnt_o, proto_err_o, timeout_o.
- start_o: next = 0 if start_o|started_o, else issue_i. Only one start is possible per reset.
- started_o: set when start_o=1.
- cycle_cnt_o: increments when (start_o|started_o) and cnt < CNT_SAT; otherwise holds.
- adv[k] = stage_o[k] & ~stall_i[k].
- stage_o[0] = start_o & s1_valid_i & ~stall_i[0].
- For k≥1: when ~stall_i[k], stage_o[k] <= adv[k-1]; otherwise it holds.
- commit_o <= adv[N-1] every cycle.
- If start_o=1 with s1_valid_i=0 or stall_i[0]=1, the marker never enters. No commit follows, and this is legal.
- proto_err_o: set when adv[k-1] & stall_i[k] for any k≥1 (marker dropped because a downstream stage stalled while the upstream stage advanced).
- iend_o = commit_o & started_o & ~ended_o & (cycle_cnt_o ≤ MAX_CYCLES).
- ended_o: set on iend_o.
- ended2_o: set when commit_o & started_o & ended_o & ~ended2_o.
- A late commit (cnt > MAX_CYCLES) never sets ended_o.

## Timing
- With no stalls: start_o at cycle T+1 after issue_i at T. stage_o[0] at T+1, stage_o[k] at T+1+k, commit_o at T+1+N. cycle_cnt_o equals N when commit_o is high.
- Each stall cycle at the marker's stage adds one cycle of latency.
- iend_o has zero latency from commit_o; ended_o follows one cycle later.
- Reset asserted mid-flight clears the marker immediately. After release, one new start is allowed.

## Configuration
- L2_MON_TIMEOUT_EN defined: timeout_o is set when started_o & ~ended_o & cycle_cnt_o > MAX_CYCLES, and it stays sticky.
- L2_MON_TIMEOUT_EN undefined: timeout_o is tied to 0 and its logic is not compiled in.

## Structure
- Shared package l2_mon_pkg holds default parameter constants and the stage-index typedef.
- One sub-module, l2_mon_stage: a single stall-gated marker register that outputs adv. It is instantiated NUM_STAGES-1 times in a generate loop.

## Test plan
- N=4, issue_i=1 at cycle 0, s1_valid_i=1, no stalls → start_o@1, commit_o@5, iend_o@5 with cnt=4, ended_o@6.
- stall_i[2]=1 for 3 cycles while marker is in S3 → commit_o@8, cnt=7, proto_err_o stays 0.
- s1_valid_i=0 during start_o → stage_o stays 0, no commit, cnt saturates at 132, ended_o=0.
- stall_i[1]=1 in the same cycle stage_o[0]=1 and stall_i[0]=0 → proto_err_o=1 next cycle, marker lost.
- MAX_CYCLES=3, N=4, no stalls → commit at cnt=4, iend_o=0. With L2_MON_TIMEOUT_EN defined, timeout_o=1 once cnt=4.
- rst_n low at cycle 3 mid-flight, released at cycle 5, issue_i held high → all outputs clear immediately; restart gives start_o@6, commit_o@10.
